// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem request, IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN adds the fetch_misalign output and a HALT state.
module fetch_stage #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic            fetch_misalign,
`endif
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [31:0]     if_id_instr,
  output logic [6:0]      if_id_opcode
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
`ifdef FETCH_MISALIGN_CHECK_EN
    , HALT
`endif
  } state_t;

  state_t          state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [31:0]     skid_instr;
  logic            skid_load;
  logic            load;
  logic [31:0]     load_instr;
  logic            flush;
  logic            busy;
  logic            redirect_take;
  logic [XLEN-1:0] redir_pc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic            misalign_set;
`endif

  assign imem_req_valid = (state == REQ);
  assign imem_req_addr  = pc;
  assign if_id_opcode   = if_id_instr[6:0];
  assign redir_pc       = redirect_pc & ~XLEN'(3);

  always_comb begin
    state_next    = state;
    pc_next       = pc;
    load          = 1'b0;
    load_instr    = imem_rsp_data;
    skid_load     = 1'b0;
    flush         = 1'b0;
    redirect_take = redirect_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_set  = 1'b0;
    if (state == HALT) redirect_take = 1'b0;
`endif
    // A request is still outstanding if it handshakes now or its response has not arrived.
    busy = ((state == REQ) && imem_req_ready) ||
           (((state == WAIT) || (state == DRAIN)) && !imem_rsp_valid);

    case (state)
      IDLE: state_next = REQ;
      REQ:  if (imem_req_ready) state_next = WAIT;
      WAIT: begin
        if (imem_rsp_valid) begin
          if (stall) begin
            skid_load  = 1'b1;
            state_next = HOLD;
          end else begin
            load       = 1'b1;
            pc_next    = pc + XLEN'(4);
            state_next = REQ;
          end
        end
      end
      HOLD: begin
        if (!stall) begin
          load       = 1'b1;
          load_instr = skid_instr;
          pc_next    = pc + XLEN'(4);
          state_next = REQ;
        end
      end
      DRAIN: begin
`ifdef FETCH_MISALIGN_CHECK_EN
        if (imem_rsp_valid) state_next = fetch_misalign ? HALT : REQ;
`else
        if (imem_rsp_valid) state_next = REQ;
`endif
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      HALT: state_next = HALT;
`endif
      default: state_next = IDLE;
    endcase

    if (redirect_take) begin
      flush      = 1'b1;
      load       = 1'b0;
      skid_load  = 1'b0;
      pc_next    = redir_pc;
      state_next = (state == IDLE) ? IDLE : (busy ? DRAIN : REQ);
`ifdef FETCH_MISALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_set = 1'b1;
        pc_next      = pc;
        state_next   = busy ? DRAIN : HALT;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (skid_load) skid_instr <= imem_rsp_data;
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)               fetch_misalign <= 1'b0;
    else if (misalign_set) fetch_misalign <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid    <= 1'b0;
      if_id_pc       <= '0;
      if_id_pc_plus4 <= XLEN'(4);
      if_id_instr    <= NOP_INSTR;
    end else if (flush) begin
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else if (!stall) begin
      if_id_valid <= load;
      if (load) begin
        if_id_pc       <= pc;
        if_id_pc_plus4 <= pc + XLEN'(4);
        if_id_instr    <= load_instr;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; imem returns 0x00500093 + (addr << 8)
// one cycle after each handshake unless the test drives the response by hand.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, redirect_pc;
  logic        stall, redirect_valid, if_id_valid;
  logic [31:0] if_id_pc, if_id_pc_plus4, if_id_instr;
  logic [6:0]  if_id_opcode;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif
  int n_cmp = 0;
  int n_err = 0;
  logic auto_rsp = 1'b1;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign(fetch_misalign),
`endif
    .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4),
    .if_id_instr(if_id_instr), .if_id_opcode(if_id_opcode)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'h0050_0093 + (a << 8);
  endfunction

  task automatic step();
    logic        hs;
    logic [31:0] a;
    hs = imem_req_valid && imem_req_ready;
    a  = imem_req_addr;
    @(posedge clk); #1;
    if (auto_rsp) begin
      imem_rsp_valid = hs;
      imem_rsp_data  = hs ? memf(a) : 32'h0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    step(); step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL rst_if_id_valid: got %b want 0", if_id_valid); end
    n_cmp++; if (if_id_pc !== 32'h0) begin n_err++; $display("FAIL rst_if_id_pc: got %h want 0", if_id_pc); end
    n_cmp++; if (if_id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL rst_pc_plus4: got %h want 4", if_id_pc_plus4); end
    n_cmp++; if (if_id_instr !== 32'h13) begin n_err++; $display("FAIL rst_instr: got %h want 00000013", if_id_instr); end
`ifdef FETCH_MISALIGN_CHECK_EN
    n_cmp++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL rst_misalign: got %b want 0", fetch_misalign); end
`endif
  endtask

  task automatic test_first_fetch();
    rst = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL first_req: got v=%b a=%h want v=1 a=0", imem_req_valid, imem_req_addr); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL wait_req: got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || if_id_pc_plus4 !== 32'h4) begin n_err++; $display("FAIL first_ifid: got v=%b pc=%h p4=%h want 1/0/4", if_id_valid, if_id_pc, if_id_pc_plus4); end
    n_cmp++; if (if_id_instr !== 32'h0050_0093 || if_id_opcode !== 7'b0010011) begin n_err++; $display("FAIL first_instr: got %h op=%b want 00500093 op=0010011", if_id_instr, if_id_opcode); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h4) begin n_err++; $display("FAIL second_req: got v=%b a=%h want v=1 a=4", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_sequential();
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL seq_bubble%0d: got %b want 0", i, if_id_valid); end
      step();
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'(i * 4) || if_id_pc_plus4 !== 32'(i * 4 + 4)) begin n_err++; $display("FAIL seq_ifid%0d: got v=%b pc=%h p4=%h want pc=%0h", i, if_id_valid, if_id_pc, if_id_pc_plus4, i * 4); end
      n_cmp++; if (if_id_instr !== 32'h0050_0093 + 32'(i << 10)) begin n_err++; $display("FAIL seq_instr%0d: got %h", i, if_id_instr); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hC || if_id_instr !== 32'h0050_0C93) begin n_err++; $display("FAIL stall_hold%0d: got v=%b pc=%h i=%h want 1/c/00500c93", i, if_id_valid, if_id_pc, if_id_instr); end
      n_cmp++; if (i > 0 && imem_req_valid !== 1'b0) begin n_err++; $display("FAIL stall_noreq%0d: got %b want 0", i, imem_req_valid); end
    end
    stall = 1'b0;
    step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h10 || if_id_instr !== 32'h0050_1093) begin n_err++; $display("FAIL stall_release: got v=%b pc=%h i=%h want 1/10/00501093", if_id_valid, if_id_pc, if_id_instr); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h14) begin n_err++; $display("FAIL stall_next_req: got v=%b a=%h want 1/14", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_wait();
    auto_rsp = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    redirect_valid = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_err++; $display("FAIL rw_flush: got v=%b i=%h want 0/00000013", if_id_valid, if_id_instr); end
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_drain_req: got %b want 0", imem_req_valid); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b0) begin n_err++; $display("FAIL rw_drain_req2: got %b want 0", imem_req_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_006F;
    step();
    imem_rsp_valid = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin n_err++; $display("FAIL rw_new_req: got v=%b a=%h want 1/100", imem_req_valid, imem_req_addr); end
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_err++; $display("FAIL rw_discard: got v=%b i=%h want 0/00000013", if_id_valid, if_id_instr); end
    auto_rsp = 1'b1;
    step(); step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h100 || if_id_instr !== 32'h0051_0093) begin n_err++; $display("FAIL rw_fetch: got v=%b pc=%h i=%h want 1/100/00510093", if_id_valid, if_id_pc, if_id_instr); end
  endtask

  task automatic test_redirect_rsp();
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h200; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    n_cmp++; if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_err++; $display("FAIL rr_flush: got v=%b i=%h want 0/00000013", if_id_valid, if_id_instr); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin n_err++; $display("FAIL rr_req: got v=%b a=%h want 1/200", imem_req_valid, imem_req_addr); end
    step(); step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h200 || if_id_pc_plus4 !== 32'h204 || if_id_instr !== 32'h0052_0093) begin n_err++; $display("FAIL rr_fetch: got v=%b pc=%h p4=%h i=%h", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
  endtask

  task automatic test_wrap();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_withdraw: got v=%b a=%h want 1/fffffffc", imem_req_valid, imem_req_addr); end
    step(); step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'hFFFF_FFFC || if_id_pc_plus4 !== 32'h0 || if_id_instr !== 32'h004F_FC93) begin n_err++; $display("FAIL wrap_ifid: got v=%b pc=%h p4=%h i=%h", if_id_valid, if_id_pc, if_id_pc_plus4, if_id_instr); end
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got v=%b a=%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_stale();
    auto_rsp = 1'b0; imem_rsp_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (imem_req_valid !== 1'b0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL midrst: got rv=%b iv=%b want 0/0", imem_req_valid, if_id_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_006F;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || if_id_valid !== 1'b0 || if_id_instr !== 32'h13) begin n_err++; $display("FAIL stale_idle: got rv=%b a=%h iv=%b i=%h", imem_req_valid, imem_req_addr, if_id_valid, if_id_instr); end
    imem_req_ready = 1'b0;
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || if_id_valid !== 1'b0) begin n_err++; $display("FAIL stale_req: got rv=%b a=%h iv=%b", imem_req_valid, imem_req_addr, if_id_valid); end
    imem_rsp_valid = 1'b0; auto_rsp = 1'b1;
  endtask

`ifdef FETCH_MISALIGN_CHECK_EN
  task automatic test_misalign();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h102;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    n_cmp++; if (fetch_misalign !== 1'b1 || if_id_valid !== 1'b0 || imem_req_valid !== 1'b0) begin n_err++; $display("FAIL mis_set: got m=%b iv=%b rv=%b want 1/0/0", fetch_misalign, if_id_valid, imem_req_valid); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (imem_req_valid !== 1'b0 || fetch_misalign !== 1'b1) begin n_err++; $display("FAIL mis_halt%0d: got rv=%b m=%b want 0/1", i, imem_req_valid, fetch_misalign); end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (fetch_misalign !== 1'b0) begin n_err++; $display("FAIL mis_clear: got %b want 0", fetch_misalign); end
    step();
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin n_err++; $display("FAIL mis_restart: got v=%b a=%h want 1/0", imem_req_valid, imem_req_addr); end
  endtask
`else
  task automatic test_align();
    imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    redirect_valid = 1'b0; imem_req_ready = 1'b1;
    n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h300) begin n_err++; $display("FAIL align_addr: got v=%b a=%h want 1/300", imem_req_valid, imem_req_addr); end
    step(); step();
    n_cmp++; if (if_id_valid !== 1'b1 || if_id_pc !== 32'h300 || if_id_pc_plus4 !== 32'h304) begin n_err++; $display("FAIL align_ifid: got v=%b pc=%h p4=%h want 1/300/304", if_id_valid, if_id_pc, if_id_pc_plus4); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_fetch();
    test_sequential();
    test_stall();
    test_redirect_wait();
    test_redirect_rsp();
    test_wrap();
    test_stale();
`ifdef FETCH_MISALIGN_CHECK_EN
    test_misalign();
`else
    test_align();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
